pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multi-cycle fetch/issue controller that drives the 4-bit PC_control of the program counter.
- Fetches one instruction per pass over a req/ack instruction-memory handshake and latches it.
- Decodes the jump and branch class, resolves the branch condition, and issues exactly one PC update per instruction.
- Drives the HOLD code on every other cycle. The PC has no enable, and any code outside 0000–0011 leaves it unchanged.

Parameters:
- ACK_TIMEOUT, 16: FETCH cycles without imem_ack before the error trap is raised (legal range 2–255).
- HOLD_CODE, 4'b1111: PC_control value that leaves the PC unchanged.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- imem_ack  in  1  instruction memory returns instr_data this cycle
- instr_data  in  32  instruction word, valid when imem_ack=1
- stall  in  1  downstream datapath not ready; hold in EXEC
- alu_zero  in  1  branch compare result, valid during EXEC
- imem_req  out  1  fetch request at the current PC
- instr_q  out  32  latched instruction
- instr_valid  out  1  instr_q is valid (EXEC state)
- PC_control  out  4  next-PC select: 0000 seq, 0001 jump, 0010 register, 0011 branch, HOLD_CODE hold
- fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT, imem_req=0, instr_q=0, instr_valid=0, PC_control=HOLD_CODE, fetch_err=0, timeout counter=0.
- BOOT:
  - One cycle after rst deasserts, with HOLD_CODE driven. Then go to FETCH.
  - Purpose: the PC, also cleared by reset, keeps address 0 for the first fetch.
- FETCH:
  - imem_req=1, PC_control=HOLD_CODE, counter increments each cycle.
  - On imem_ack=1: latch instr_data into instr_q, clear the counter, go to EXEC. An ack in the first FETCH cycle is legal.
  - If imem_ack=1 arrives in the same cycle the counter reaches ACK_TIMEOUT-1, the ack wins.
  - Counter reaching ACK_TIMEOUT-1 without ack: go to TRAP.
  - imem_ack outside FETCH is ignored.
- EXEC:
  - imem_req=0, instr_valid=1.
  - While stall=1: PC_control=HOLD_CODE, stay in EXEC, instr_q stable.
  - When stall=0: PC_control is decoded combinationally from instr_q and alu_zero for this one cycle, then go to FETCH.
  - The PC updates on the same edge that leaves EXEC.
  - Minimum throughput: 2 cycles per instruction.
- Decode (op=instr_q[31:26], funct=instr_q[5:0]):
  - op 000010 (j) or 000011 (jal) -> 0001
  - op 000000 and funct 001000 (jr) -> 0010
  - op 000100 (beq): 0011 if alu_zero=1, else 0000
  - op 000101 (bne): 0011 if alu_zero=0, else 0000
  - any other value -> 0000
- TRAP:
  - fetch_err=1 (sticky), imem_req=0, PC_control=HOLD_CODE.
  - Exit only by reset.
- PC_control is a Moore/Mealy mix:
  - HOLD_CODE in every state except EXEC with stall=0.
  - Never X; no glitch-dependent timing. The PC samples it at the clock edge.
- Reset mid-fetch or mid-EXEC: everything returns to reset values immediately; no PC update is issued.

Optional Feature:
- Macro: PC_SEQ_PERF_CNT_EN
- Defined:
  - Adds outputs retired_cnt[31:0] (increments on each EXEC exit) and stall_cnt[31:0] (increments on each EXEC cycle with stall=1, plus each FETCH cycle without ack).
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Release reset, ack in the first FETCH cycle with instr 0x20080005 (addi), stall=0 -> PC_control=HOLD on boot and fetch cycles, 0000 exactly one cycle in EXEC, imem_req reasserts the next cycle.
- instr 0x08000010 (j) -> 0001 for one cycle. instr 0x03E00008 (jr $ra) -> 0010.
- instr 0x1109FFFF (beq): alu_zero=1 -> 0011; repeated with alu_zero=0 -> 0000. instr 0x1509FFFF (bne): alu_zero=0 -> 0011.
- stall=1 for 3 EXEC cycles -> HOLD for 3 cycles, instr_valid=1 and instr_q constant; the code issues on the 4th cycle.
- Ack withheld with ACK_TIMEOUT=4 -> TRAP entered after the 4th FETCH cycle, fetch_err=1, imem_req=0; a late ack is ignored; rst=0 clears the trap.
- rst pulsed low while in EXEC -> outputs return to reset values asynchronously; with PC_SEQ_PERF_CNT_EN, retired_cnt=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/issue controller driving the program counter's PC_control select.
// Optional PC_SEQ_PERF_CNT_EN adds retired_cnt / stall_cnt performance counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_BOOT  | one idle cycle after reset so the PC still holds address 0
// S_FETCH | imem_req high, waiting for imem_ack (bounded by ACK_TIMEOUT)
// S_EXEC  | instr_q valid; issue one PC update when stall drops
// S_TRAP  | fetch timed out; sticky until reset
module pc_sequencer #(
   parameter int         ACK_TIMEOUT = 16,
   parameter logic [3:0] HOLD_CODE   = 4'b1111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_ack,
   input  logic [31:0] instr_data,
   input  logic        stall,
   input  logic        alu_zero,
   output logic        imem_req,
   output logic [31:0] instr_q,
   output logic        instr_valid,
   output logic [3:0]  PC_control,
   output logic        fetch_err
`ifdef PC_SEQ_PERF_CNT_EN
   ,
   output logic [31:0] retired_cnt,
   output logic [31:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_TRAP} state_t;

   localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

   localparam logic [3:0] PC_SEQ    = 4'b0000;
   localparam logic [3:0] PC_JUMP   = 4'b0001;
   localparam logic [3:0] PC_REG    = 4'b0010;
   localparam logic [3:0] PC_BRANCH = 4'b0011;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] ack_cnt;
   logic [3:0] decode_code;
   logic [5:0] op;
   logic [5:0] funct;

   assign op    = instr_q[31:26];
   assign funct = instr_q[5:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_BOOT;
         ack_cnt <= '0;
         instr_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH && !imem_ack)
            ack_cnt <= ack_cnt + 8'd1;
         else
            ack_cnt <= '0;
         if (state == S_FETCH && imem_ack)
            instr_q <= instr_data;
      end
   end

   // An ack in the last allowed cycle takes priority over the timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         S_BOOT:  state_nxt = S_FETCH;
         S_FETCH: begin
            if (imem_ack)
               state_nxt = S_EXEC;
            else if (ack_cnt == ACK_LAST)
               state_nxt = S_TRAP;
         end
         S_EXEC:  if (!stall) state_nxt = S_FETCH;
         S_TRAP:  state_nxt = S_TRAP;
         default: state_nxt = S_BOOT;
      endcase
   end

   always_comb begin
      decode_code = PC_SEQ;
      case (op)
         6'b000010, 6'b000011: decode_code = PC_JUMP;
         6'b000000:            if (funct == 6'b001000) decode_code = PC_REG;
         6'b000100:            if (alu_zero) decode_code = PC_BRANCH;
         6'b000101:            if (!alu_zero) decode_code = PC_BRANCH;
         default:              decode_code = PC_SEQ;
      endcase
   end

   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      fetch_err   = 1'b0;
      PC_control  = HOLD_CODE;
      case (state)
         S_FETCH: imem_req = 1'b1;
         S_EXEC: begin
            instr_valid = 1'b1;
            if (!stall) PC_control = decode_code;
         end
         S_TRAP:  fetch_err = 1'b1;
         default: ;
      endcase
   end

`ifdef PC_SEQ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retired_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if (state == S_EXEC && !stall)
            retired_cnt <= retired_cnt + 32'd1;
         if ((state == S_EXEC && stall) || (state == S_FETCH && !imem_ack))
            stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a transaction-level model sets the expected
// outputs for every cycle and one negedge process compares the DUT against it.
module tb_pc_sequencer;

   localparam logic [3:0] HOLD = 4'b1111;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_ack;
   logic [31:0] instr_data;
   logic        stall;
   logic        alu_zero;
   logic        imem_req;
   logic [31:0] instr_q;
   logic        instr_valid;
   logic [3:0]  PC_control;
   logic        fetch_err;
`ifdef PC_SEQ_PERF_CNT_EN
   logic [31:0] retired_cnt;
   logic [31:0] stall_cnt;
`endif

   pc_sequencer #(.ACK_TIMEOUT(4), .HOLD_CODE(HOLD)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_ack    (imem_ack),
      .instr_data  (instr_data),
      .stall       (stall),
      .alu_zero    (alu_zero),
      .imem_req    (imem_req),
      .instr_q     (instr_q),
      .instr_valid (instr_valid),
      .PC_control  (PC_control),
      .fetch_err   (fetch_err)
`ifdef PC_SEQ_PERF_CNT_EN
      ,
      .retired_cnt (retired_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        chk_en = 1'b0;
   logic        exp_req, exp_valid, exp_err;
   logic [3:0]  exp_pc;
   logic [31:0] exp_q;
   logic [31:0] exp_ret, exp_stl;
   logic        cyc_ret, cyc_stl;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] ref_pc(input logic [31:0] ins, input logic az);
      logic [5:0] opc;
      opc = ins[31:26];
      if (opc == 6'd2 || opc == 6'd3) return 4'b0001;
      if (opc == 6'd0 && ins[5:0] == 6'd8) return 4'b0010;
      if (opc == 6'd4) return az ? 4'b0011 : 4'b0000;
      if (opc == 6'd5) return az ? 4'b0000 : 4'b0011;
      return 4'b0000;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
         chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
         chk("fetch_err", {31'b0, fetch_err}, {31'b0, exp_err});
         chk("PC_control", {28'b0, PC_control}, {28'b0, exp_pc});
         chk("instr_q", instr_q, exp_q);
`ifdef PC_SEQ_PERF_CNT_EN
         chk("retired_cnt", retired_cnt, exp_ret);
         chk("stall_cnt", stall_cnt, exp_stl);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      if (rst) begin
         exp_ret += {31'b0, cyc_ret};
         exp_stl += {31'b0, cyc_stl};
      end
      #1;
      cyc_ret = 1'b0;
      cyc_stl = 1'b0;
   endtask

   task automatic expect_idle(input logic err);
      exp_req   = 1'b0;
      exp_valid = 1'b0;
      exp_err   = err;
      exp_pc    = HOLD;
   endtask

   task automatic assert_reset();
      rst = 1'b0;
      expect_idle(1'b0);
      exp_q   = '0;
      exp_ret = '0;
      exp_stl = '0;
      cyc_ret = 1'b0;
      cyc_stl = 1'b0;
   endtask

   task automatic boot();
      rst = 1'b1;
      imem_ack = 1'b0;
      expect_idle(1'b0);
      step();
   endtask

   task automatic fetch(input int waits, input logic [31:0] ins);
      for (int i = 0; i < waits; i++) begin
         imem_ack   = 1'b0;
         instr_data = $urandom;
         stall      = 1'($urandom_range(0, 1));
         exp_req = 1'b1; exp_valid = 1'b0; exp_err = 1'b0; exp_pc = HOLD;
         cyc_stl = 1'b1;
         step();
      end
      imem_ack   = 1'b1;
      instr_data = ins;
      exp_req = 1'b1; exp_valid = 1'b0; exp_err = 1'b0; exp_pc = HOLD;
      step();
      imem_ack   = 1'b0;
      instr_data = $urandom;
      exp_q      = ins;
   endtask

   task automatic exec(input int stalls, input logic az, input logic [3:0] lit);
      for (int i = 0; i < stalls; i++) begin
         stall      = 1'b1;
         imem_ack   = 1'b1;
         instr_data = $urandom;
         alu_zero   = 1'($urandom_range(0, 1));
         exp_req = 1'b0; exp_valid = 1'b1; exp_err = 1'b0; exp_pc = HOLD;
         cyc_stl = 1'b1;
         step();
      end
      imem_ack = 1'b0;
      stall    = 1'b0;
      alu_zero = az;
      exp_req = 1'b0; exp_valid = 1'b1; exp_err = 1'b0;
      exp_pc  = ref_pc(exp_q, az);
      cyc_ret = 1'b1;
      @(negedge clk);
      chk("issue_code_literal", {28'b0, PC_control}, {28'b0, lit});
      step();
   endtask

   initial begin
      imem_ack   = 1'b0;
      instr_data = '0;
      stall      = 1'b0;
      alu_zero   = 1'b0;
      cyc_ret    = 1'b0;
      cyc_stl    = 1'b0;
      assert_reset();
      chk_en = 1'b1;
      step();
      step();
      boot();

      fetch(0, 32'h2008_0005); exec(0, 1'b0, 4'b0000);
      fetch(0, 32'h0800_0010); exec(0, 1'b0, 4'b0001);
      fetch(2, 32'h03E0_0008); exec(0, 1'b1, 4'b0010);
      fetch(1, 32'h1109_FFFF); exec(0, 1'b1, 4'b0011);
      fetch(0, 32'h1109_FFFF); exec(0, 1'b0, 4'b0000);
      fetch(0, 32'h1509_FFFF); exec(3, 1'b0, 4'b0011);
      fetch(0, 32'h1509_FFFF); exec(0, 1'b1, 4'b0000);
      fetch(3, 32'h0C00_0020); exec(1, 1'b0, 4'b0001);
      fetch(3, 32'h2008_0005); exec(2, 1'b1, 4'b0000);

      // Asynchronous reset while stalled in EXEC.
      fetch(0, 32'h0800_0010);
      stall = 1'b1;
      exp_req = 1'b0; exp_valid = 1'b1; exp_err = 1'b0; exp_pc = HOLD;
      cyc_stl = 1'b1;
      step();
      stall = 1'b0;
      assert_reset();
      #1;
      chk("async_rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("async_rst_pc", {28'b0, PC_control}, {28'b0, HOLD});
      chk("async_rst_instr_q", instr_q, 32'd0);
`ifdef PC_SEQ_PERF_CNT_EN
      chk("async_rst_retired", retired_cnt, 32'd0);
`endif
      step();
      boot();

      // Ack withheld: four FETCH cycles, then TRAP; late acks are ignored.
      fetch(0, 32'h1109_FFFF); exec(0, 1'b1, 4'b0011);
      for (int i = 0; i < 4; i++) begin
         imem_ack   = 1'b0;
         instr_data = $urandom;
         exp_req = 1'b1; exp_valid = 1'b0; exp_err = 1'b0; exp_pc = HOLD;
         cyc_stl = 1'b1;
         step();
      end
      for (int i = 0; i < 3; i++) begin
         imem_ack   = 1'b1;
         instr_data = $urandom;
         stall      = 1'b0;
         expect_idle(1'b1);
         step();
      end
      chk("trap_err_literal", {31'b0, fetch_err}, 32'd1);
      chk("trap_req_literal", {31'b0, imem_req}, 32'd0);
      imem_ack = 1'b0;
      assert_reset();
      #1;
      chk("trap_cleared", {31'b0, fetch_err}, 32'd0);
      step();
      boot();
      fetch(1, 32'h03E0_0008); exec(1, 1'b0, 4'b0010);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
